// File: rtl/mux_pkg.sv
// Shared definitions for the mux-select arbitration path: arbiter state
// encoding, default sizing and the rotation-pointer mask helper.
package mux_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 16;

    // Widest request vector the mask helper can describe.
    localparam int MASK_W = 64;

    // Thermometer mask with every bit at or above ptr set; callers size-cast
    // the result down to their own request width.
    function automatic logic [MASK_W-1:0] ptr_mask(input logic [31:0] ptr);
        logic [MASK_W-1:0] mask;
        mask = {MASK_W{1'b0}};
        for (int i = 0; i < MASK_W; i++) begin
            mask[i] = (32'(i) >= ptr) ? 1'b1 : 1'b0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational lowest-set-bit encoder. idx is 0 when the vector is empty;
// zero flags that case so the caller can ignore idx.
module rr_prio_enc
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);

    // Scan from the top so the last hit written is the lowest set index.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = req[i] ? IDX_W'(i) : idx;
        end
        zero = ~|req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter feeding the mux datapath select. A grant is
// held until its owner drops the request, or until MAX_HOLD consecutive
// cycles have elapsed while someone else is waiting. Every output is a flop.
module rr_grant_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IDX_W    = $clog2(WIDTH),
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_req,
    output logic [WIDTH-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_vld,
    output logic             o_empty
);

    // With preemption disabled CNT_W collapses to zero; keep one bit so the
    // counter stays a legal (constant-zero) register.
    localparam int                CNT_IW    = (CNT_W > 0) ? CNT_W : 1;
    localparam logic [CNT_IW-1:0] HOLD_LAST = CNT_IW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_IW-1:0] CNT_ONE   = CNT_IW'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [WIDTH-1:0]  BIT0      = WIDTH'(1);

    arb_state_e        state_r, state_s;
    logic [IDX_W-1:0]  ptr_r, ptr_s;
    logic [CNT_IW-1:0] hold_cnt_r, hold_cnt_s;
    logic [WIDTH-1:0]  grant_r, grant_s;
    logic [IDX_W-1:0]  grant_idx_r, grant_idx_s;
    logic              grant_vld_r, grant_vld_s;
    logic              empty_r, empty_s;

    logic [WIDTH-1:0]  cand_s;
    logic [WIDTH-1:0]  masked_s;
    logic [IDX_W-1:0]  masked_idx_s, raw_idx_s, win_idx_s, win_ptr_s;
    logic              masked_zero_s, raw_zero_s;
    logic [WIDTH-1:0]  win_onehot_s;
    logic              owner_req_s, preempt_s;
    logic              issue_s, clear_s;

    // The current owner is excluded from the candidates: on release its bit is
    // already low, and on preemption it must not win against itself.
    assign cand_s   = in_req & ~grant_r;
    assign masked_s = cand_s & WIDTH'(ptr_mask(32'(ptr_r)));

    rr_prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_masked (
        .req  (masked_s),
        .idx  (masked_idx_s),
        .zero (masked_zero_s)
    );

    rr_prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_raw (
        .req  (cand_s),
        .idx  (raw_idx_s),
        .zero (raw_zero_s)
    );

    // Nothing at or above ptr means the search wraps to the lowest requester.
    assign win_idx_s    = masked_zero_s ? raw_idx_s : masked_idx_s;
    assign win_onehot_s = BIT0 << win_idx_s;
    assign win_ptr_s    = (win_idx_s == IDX_LAST) ? {IDX_W{1'b0}} : (win_idx_s + IDX_ONE);

    assign owner_req_s = |(in_req & grant_r);
    assign preempt_s   = (MAX_HOLD != 0) && owner_req_s && !raw_zero_s &&
                         (hold_cnt_r == HOLD_LAST);

    // Next-state: decide whether to issue a fresh grant, clear, or hold.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        hold_cnt_s  = hold_cnt_r;
        grant_s     = grant_r;
        grant_idx_s = grant_idx_r;
        grant_vld_s = grant_vld_r;
        issue_s     = 1'b0;
        clear_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (!raw_zero_s) begin
                    issue_s = 1'b1;
                end else begin
                    clear_s = 1'b1;
                end
            end
            GRANT: begin
                if (owner_req_s) begin
                    if (preempt_s) begin
                        issue_s = 1'b1;
                    end else if (hold_cnt_r != HOLD_LAST) begin
                        hold_cnt_s = hold_cnt_r + CNT_ONE;
                    end else begin
                        // Saturated: a late arrival preempts at the next edge.
                        hold_cnt_s = hold_cnt_r;
                    end
                end else if (!raw_zero_s) begin
                    issue_s = 1'b1;
                end else begin
                    clear_s = 1'b1;
                end
            end
            default: begin
                clear_s = 1'b1;
            end
        endcase

        if (issue_s) begin
            state_s     = GRANT;
            grant_s     = win_onehot_s;
            grant_idx_s = win_idx_s;
            grant_vld_s = 1'b1;
            ptr_s       = win_ptr_s;
            hold_cnt_s  = {CNT_IW{1'b0}};
        end else if (clear_s) begin
            state_s     = IDLE;
            grant_s     = {WIDTH{1'b0}};
            grant_idx_s = {IDX_W{1'b0}};
            grant_vld_s = 1'b0;
            hold_cnt_s  = {CNT_IW{1'b0}};
        end else begin
            state_s = state_r;
        end

        empty_s = ~grant_vld_s & ~|in_req;
    end

    // State and output registers; reset leaves an idle, empty arbiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            hold_cnt_r  <= {CNT_IW{1'b0}};
            grant_r     <= {WIDTH{1'b0}};
            grant_idx_r <= {IDX_W{1'b0}};
            grant_vld_r <= 1'b0;
            empty_r     <= 1'b1;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            hold_cnt_r  <= hold_cnt_s;
            grant_r     <= grant_s;
            grant_idx_r <= grant_idx_s;
            grant_vld_r <= grant_vld_s;
            empty_r     <= empty_s;
        end
    end

    assign o_grant     = grant_r;
    assign o_grant_idx = grant_idx_r;
    assign o_grant_vld = grant_vld_r;
    assign o_empty     = empty_r;

endmodule
